u_boot_loader: RTL

//  Program loader/sequencer for the pipeline chip.
//  - Accepts instruction words from an external valid/ready stream.
//  - Writes them into instruction memory at sequential word addresses.
//  - Holds the CPU in reset while loading; releases it after a settle delay.
//  - Sits between chip-level pins and the ins-mem write port / CPU reset input.

---
 rtl/u_boot_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/u_boot_loader.sv
// Program loader: streams host instruction words into ins-mem at sequential
// addresses while holding the CPU in reset, then releases it after a settle delay.
module u_boot_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CNT_W       = 10,
  parameter int          TIMEOUT_CYC = 1024,
  parameter int          SETTLE_CYC  = 4
) (
  input  logic             i_sys_clock,
  input  logic             i_sys_reset,
  input  logic             i_u_boot_loader_start,
  input  logic [CNT_W-1:0] i_u_boot_loader_word_count,
  input  logic [31:0]      i_u_boot_loader_wr_ins,
  input  logic             i_u_boot_loader_wr_valid,
  output logic             o_u_boot_loader_wr_ready,
  output logic             o_u_boot_loader_ins_wr_en,
  output logic [31:0]      o_u_boot_loader_ins_wr_addr,
  output logic [31:0]      o_u_boot_loader_ins_wr_data,
  output logic             o_u_boot_loader_cpu_reset,
  output logic             o_u_boot_loader_busy,
  output logic             o_u_boot_loader_done,
  output logic             o_u_boot_loader_error,
  output logic [2:0]       o_u_boot_loader_state
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  // Handshake: a word transfers on a rising edge where wr_valid && wr_ready;
  // ready depends only on state, never on valid.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             done_q, done_d;
  logic             wr_en_q;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q;
  logic             accept;

  assign o_u_boot_loader_wr_ready = (state_q == S_LOAD);
  assign accept = o_u_boot_loader_wr_ready && i_u_boot_loader_wr_valid;
  assign addr_d = BASE_ADDR + (32'(idx_q) << 2);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    settle_d = settle_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (i_u_boot_loader_start) begin
          count_d  = i_u_boot_loader_word_count;
          idx_d    = '0;
          timer_d  = '0;
          settle_d = '0;
          state_d  = (i_u_boot_loader_word_count == '0) ? S_SETTLE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          timer_d = '0;
          // Leaving on the last accept drops ready at the same edge.
          if (idx_q == count_q - CNT_W'(1)) begin
            state_d  = S_SETTLE;
            settle_d = '0;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clock) begin
    if (!i_sys_reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= BASE_ADDR;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      settle_q <= settle_d;
      done_q   <= done_d;
      wr_en_q  <= accept;
      if (accept) begin
        addr_q <= addr_d;
        data_q <= i_u_boot_loader_wr_ins;
      end
    end
  end

  assign o_u_boot_loader_ins_wr_en   = wr_en_q;
  assign o_u_boot_loader_ins_wr_addr = addr_q;
  assign o_u_boot_loader_ins_wr_data = data_q;
  assign o_u_boot_loader_cpu_reset   = (state_q == S_RUN);
  assign o_u_boot_loader_busy        = (state_q == S_LOAD) || (state_q == S_SETTLE);
  assign o_u_boot_loader_done        = done_q;
  assign o_u_boot_loader_error       = (state_q == S_ERROR);
  assign o_u_boot_loader_state       = state_q;

endmodule
